serial_subtractor: RTL

Bit-serial N-bit subtractor computing diff = a - b - bin one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse arithmetic counterpart of the team's ripple full-adder datapath and serves area-constrained paths where a W-bit parallel subtractor is not justified. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready : operand transfer (a, b, bin)
//   out_valid/out_ready : result transfer (diff, bout)
// master drives operands and out_ready; slave is the subtractor.
interface serial_subtractor_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b - bin (mod 2^W), LSB first,
// one full-subtractor cell with a registered borrow.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - serial_subtractor_if.slave: operand handshake (in_valid/in_ready,
//          a, b, bin) and result handshake (out_valid/out_ready, diff, bout)
module serial_subtractor #(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  ra_q;
    logic [W-1:0]  rb_q;
    logic [W-1:0]  rd_q;
    logic          br_q;
    logic [CW-1:0] cnt_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic          load;
    logic          shift;
    logic [CW-1:0] cnt_inc;
    logic [W-1:0]  rd_shift;

    // Full-subtractor cell on the current LSBs and running borrow.
    logic x;
    logic y;
    logic d;
    logic b_next;

    assign x      = ra_q[0];
    assign y      = rb_q[0];
    assign d      = x ^ y ^ br_q;
    assign b_next = (~x & y) | (~(x ^ y) & br_q);

    assign cnt_inc = cnt_q + CW'(1);

    // New difference bit enters at the MSB; written this way so W = 1 works.
    always_comb begin
        rd_shift        = rd_q >> 1;
        rd_shift[W-1]   = d;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt_inc == CW'(W)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; handshake flags track the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Operand/result shift registers, borrow and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q  <= '0;
            rb_q  <= '0;
            rd_q  <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            ra_q  <= bus.a;
            rb_q  <= bus.b;
            br_q  <= bus.bin;
            cnt_q <= '0;
        end else if (shift) begin
            ra_q  <= ra_q >> 1;
            rb_q  <= rb_q >> 1;
            rd_q  <= rd_shift;
            br_q  <= b_next;
            cnt_q <= cnt_inc;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = rd_q;
    assign bus.bout      = br_q;
endmodule
